// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per
// cycle, with valid/ready handshakes on both sides, a writeback tag and a pipeline flush.
module muldiv_unit #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned TAGW   = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic [TAGW-1:0]   tag_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] res_o,
  output logic [TAGW-1:0]   tag_o,
  output logic              busy_o
);

  localparam int unsigned CntW = $clog2(DWIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DWIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic [TAGW-1:0]       tag_q, tag_d;
  logic [DWIDTH-1:0]     opnd_q, opnd_d;
  logic [2*DWIDTH-1:0]   acc_q, acc_d;
  logic                  neg_q, neg_d;
  logic [DWIDTH-1:0]     res_q, res_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic                  signed_a, signed_b, sign_a, sign_b;
  logic [DWIDTH-1:0]     mag_a, mag_b;
  logic                  signed_div, div_zero, div_ovf, special;
  logic [DWIDTH-1:0]     special_res;
  logic [DWIDTH:0]       mul_sum;
  logic [2*DWIDTH-1:0]   mul_step;
  logic [DWIDTH:0]       div_shift, div_diff;
  logic [2*DWIDTH-1:0]   div_step;
  logic [2*DWIDTH-1:0]   prod_fix;
  logic [DWIDTH-1:0]     lo_fix, hi_fix, calc_res;

  assign accept = valid_i & ready_q & ~flush_i;

  // Operand decode at accept time
  always_comb begin
    signed_a    = (funct3_i == 3'b001) | (funct3_i == 3'b010) |
                  (funct3_i == 3'b100) | (funct3_i == 3'b110);
    signed_b    = (funct3_i == 3'b001) | (funct3_i == 3'b100) | (funct3_i == 3'b110);
    sign_a      = signed_a & rs1_i[DWIDTH-1];
    sign_b      = signed_b & rs2_i[DWIDTH-1];
    mag_a       = sign_a ? -rs1_i : rs1_i;
    mag_b       = sign_b ? -rs2_i : rs2_i;
    signed_div  = funct3_i[2] & ~funct3_i[0];
    div_zero    = (rs2_i == '0);
    div_ovf     = signed_div & (rs1_i == {1'b1, {(DWIDTH-1){1'b0}}}) & (&rs2_i);
    special     = funct3_i[2] & (div_zero | div_ovf);
    if (div_zero) begin
      special_res = funct3_i[1] ? rs1_i : '1;
    end else begin
      special_res = funct3_i[1] ? '0 : rs1_i;
    end
  end

  // One iteration step: acc holds {partial/remainder, multiplier/dividend-quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step  = {mul_sum, acc_q[DWIDTH-1:1]};
    div_shift = {acc_q[2*DWIDTH-1:DWIDTH], acc_q[DWIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_diff[DWIDTH]) begin
      div_step = {div_shift[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b0};
    end else begin
      div_step = {div_diff[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b1};
    end
  end

  // Sign fix and result select after the last step
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    lo_fix   = neg_q ? -acc_q[DWIDTH-1:0] : acc_q[DWIDTH-1:0];
    hi_fix   = neg_q ? -acc_q[2*DWIDTH-1:DWIDTH] : acc_q[2*DWIDTH-1:DWIDTH];
    case (op_q)
      3'b000:                 calc_res = prod_fix[DWIDTH-1:0];
      3'b001, 3'b010, 3'b011: calc_res = prod_fix[2*DWIDTH-1:DWIDTH];
      3'b100, 3'b101:         calc_res = lo_fix;
      default:                calc_res = hi_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    tag_d   = tag_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    res_d   = res_q;
    valid_d = valid_q;
    ready_d = ready_q;
    busy_d  = busy_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = funct3_i;
          tag_d   = tag_i;
          opnd_d  = mag_b;
          acc_d   = {{DWIDTH{1'b0}}, mag_a};
          // Remainder takes the dividend's sign; product and quotient the XOR
          neg_d   = (funct3_i[2] & funct3_i[1]) ? sign_a : (sign_a ^ sign_b);
          cnt_d   = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if (special) begin
            res_d   = special_res;
            valid_d = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (cnt_q == LastCnt) begin
          res_d   = calc_res;
          valid_d = 1'b1;
          state_d = StDone;
        end else begin
          acc_d = op_q[2] ? div_step : mul_step;
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (ready_i) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      valid_d = 1'b0;
      ready_d = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign res_o   = res_q;
  assign tag_o   = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, handshake/flush/reset sequences and random ops
// checked against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

  localparam int DW      = 32;
  localparam int TW      = 5;
  localparam int LatIter = DW + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          valid_i;
  logic          ready_o;
  logic [2:0]    funct3_i;
  logic [DW-1:0] rs1_i;
  logic [DW-1:0] rs2_i;
  logic [TW-1:0] tag_i;
  logic          flush_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] res_o;
  logic [TW-1:0] tag_o;
  logic          busy_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  muldiv_unit #(.DWIDTH(DW), .TAGW(TW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .tag_i    (tag_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .res_o    (res_o),
    .tag_o    (tag_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add_vec(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
    vec_t v;
    v.name = name; v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    vq.push_back(v);
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin p = ua / ub; r = p[31:0]; end
      end
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && (b == 0 ||
           (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Present a request and return #1 after the accepting edge, with inputs scrambled.
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [TW-1:0] tag);
    int n = 0;
    @(negedge clk);
    funct3_i = f3; rs1_i = a; rs2_i = b; tag_i = tag; valid_i = 1'b1;
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) check("accept_wait", {63'b0, ready_o}, 64'd1);
    @(posedge clk);
    #1;
    valid_i  = 1'b0;
    funct3_i = 3'($urandom);
    rs1_i    = $urandom;
    rs2_i    = $urandom;
    tag_i    = TW'($urandom);
  endtask

  // Count edges after accept until valid_o is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!valid_o && lat < 100);
    if (!valid_o) check("result_timeout", {63'b0, valid_o}, 64'd1);
  endtask

  task automatic consume();
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
  endtask

  initial begin
    int          lat;
    int          ok_seen;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [TW-1:0] tg;

    reset_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; rs1_i = '0; rs2_i = '0; tag_i = '0;
    repeat (3) @(negedge clk);
    check("reset_valid", {63'b0, valid_o}, 64'd0);
    check("reset_ready", {63'b0, ready_o}, 64'd1);
    check("reset_busy",  {63'b0, busy_o},  64'd0);
    check("reset_res",   {32'b0, res_o},   64'd0);
    check("reset_tag",   {59'b0, tag_o},   64'd0);
    reset_n = 1'b1;

    // Directed vector table
    add_vec("mul",      3'd0, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, LatIter);
    add_vec("mulh",     3'd1, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, LatIter);
    add_vec("mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LatIter);
    add_vec("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, LatIter);
    add_vec("div",      3'd4, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, LatIter);
    add_vec("rem",      3'd6, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, LatIter);
    add_vec("divu",     3'd5, 32'd100,       32'd7,         32'd14,        LatIter);
    add_vec("remu",     3'd7, 32'd100,       32'd7,         32'd2,         LatIter);
    add_vec("div0",     3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    add_vec("rem0",     3'd6, 32'd5,         32'd0,         32'd5,         1);
    add_vec("divu0",    3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    add_vec("remu0",    3'd7, 32'd9,         32'd0,         32'd9,         1);
    add_vec("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    add_vec("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
    add_vec("divu_big", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         LatIter);
    add_vec("rem_neg",  3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         LatIter);

    for (int i = 0; i < vq.size(); i++) begin
      tg = TW'(i + 5);
      start_op(vq[i].f3, vq[i].a, vq[i].b, tg);
      wait_result(lat);
      check({vq[i].name, "_res"}, {32'b0, res_o}, {32'b0, vq[i].exp});
      check({vq[i].name, "_tag"}, {59'b0, tag_o}, {59'b0, tg});
      check({vq[i].name, "_lat"}, 64'(lat), 64'(vq[i].lat));
      consume();
    end

    // Reset in the middle of CALC
    start_op(3'd0, 32'd1234, 32'd5678, 5'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mid_valid", {63'b0, valid_o}, 64'd0);
    check("rst_mid_ready", {63'b0, ready_o}, 64'd1);
    check("rst_mid_busy",  {63'b0, busy_o},  64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    start_op(3'd0, 32'd1234, 32'd5678, 5'd4);
    wait_result(lat);
    check("rst_after_res", {32'b0, res_o}, 64'd7006652);
    check("rst_after_lat", 64'(lat), 64'(LatIter));
    consume();

    // Backpressure in DONE
    start_op(3'd5, 32'd100, 32'd7, 5'd9);
    wait_result(lat);
    repeat (4) begin
      @(negedge clk);
      check("bp_res",   {32'b0, res_o},   64'd14);
      check("bp_tag",   {59'b0, tag_o},   64'd9);
      check("bp_valid", {63'b0, valid_o}, 64'd1);
      check("bp_ready", {63'b0, ready_o}, 64'd0);
    end
    consume();
    check("bp_rel_ready", {63'b0, ready_o}, 64'd1);
    check("bp_rel_valid", {63'b0, valid_o}, 64'd0);
    check("bp_rel_busy",  {63'b0, busy_o},  64'd0);

    // Flush mid-CALC
    start_op(3'd4, 32'd1000, 32'd3, 5'd11);
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush_calc_busy",  {63'b0, busy_o},  64'd0);
    check("flush_calc_ready", {63'b0, ready_o}, 64'd1);
    ok_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid_o) ok_seen = 1;
    end
    check("flush_calc_novalid", 64'(ok_seen), 64'd0);

    // Flush together with a request in IDLE
    @(negedge clk);
    funct3_i = 3'd4; rs1_i = 32'd5; rs2_i = 32'd0; tag_i = 5'd1;
    valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0; flush_i = 1'b0;
    check("flush_idle_busy", {63'b0, busy_o}, 64'd0);
    @(posedge clk);
    #1;
    check("flush_idle_valid", {63'b0, valid_o}, 64'd0);
    check("flush_idle_ready", {63'b0, ready_o}, 64'd1);

    // Flush in DONE
    start_op(3'd6, 32'd5, 32'd0, 5'd2);
    wait_result(lat);
    check("flush_done_pre", {63'b0, valid_o}, 64'd1);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush_done_valid", {63'b0, valid_o}, 64'd0);
    check("flush_done_ready", {63'b0, ready_o}, 64'd1);

    // Random ops against the model
    for (int i = 0; i < 150; i++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 40) - 20; b = $urandom_range(0, 10) - 5; end
        3: a = 32'h8000_0000;
        default: ;
      endcase
      tg = TW'($urandom);
      start_op(f3, a, b, tg);
      wait_result(lat);
      check("rand_res", {32'b0, res_o}, {32'b0, model(f3, a, b)});
      check("rand_tag", {59'b0, tag_o}, {59'b0, tg});
      check("rand_lat", 64'(lat), is_special(f3, a, b) ? 64'd1 : 64'(LatIter));
      consume();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
